// File: rtl/imm_pkg.sv
// Shared definitions for the immediate-generation path: extension selects,
// RV32I opcodes and the buffered entry layout.
package imm_pkg;

  localparam logic [2:0] SEL_ITYPE = 3'd0;
  localparam logic [2:0] SEL_STYPE = 3'd1;
  localparam logic [2:0] SEL_BTYPE = 3'd2;
  localparam logic [2:0] SEL_UTYPE = 3'd3;
  localparam logic [2:0] SEL_JTYPE = 3'd4;
  localparam logic [2:0] SEL_NONE  = 3'b111;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef struct packed {
    logic [31:0] imm;
    logic [31:0] pc;
    logic [2:0]  sel;
    logic        illegal;
  } fifo_ent_t;

endpackage

// File: rtl/SignExten.sv
// RV32I immediate extraction and sign extension; imm_in is instr[31:7],
// so instr bit k sits at imm_in[k-7].
module SignExten
  import imm_pkg::*;
(
  input  logic [2:0]  ExtenSel,
  input  logic [24:0] imm_in,
  output logic [31:0] imm_out
);

  always_comb begin
    imm_out = '0;
    case (ExtenSel)
      SEL_ITYPE: imm_out = {{20{imm_in[24]}}, imm_in[24:13]};
      SEL_STYPE: imm_out = {{20{imm_in[24]}}, imm_in[24:18], imm_in[4:0]};
      SEL_BTYPE: imm_out = {{20{imm_in[24]}}, imm_in[0], imm_in[23:18], imm_in[4:1], 1'b0};
      SEL_UTYPE: imm_out = {imm_in[24:5], 12'b0};
      SEL_JTYPE: imm_out = {{12{imm_in[24]}}, imm_in[12:5], imm_in[13], imm_in[23:14], 1'b0};
      default:   imm_out = '0;
    endcase
  end

endmodule

// File: rtl/imm_gen_ctrl.sv
// Decodes the opcode, extends the immediate and queues {imm, pc, sel, illegal}
// in a 2-entry FIFO; every output is taken from registered state.
module imm_gen_ctrl
  import imm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_imm,
  output logic [31:0] out_pc,
  output logic [2:0]  out_sel,
  output logic        out_illegal
);

  logic [2:0]  dec_sel;
  logic        dec_ill;
  logic [31:0] ext_imm;
  fifo_ent_t   new_ent;

  always_comb begin
    dec_sel = SEL_NONE;
    dec_ill = 1'b0;
    case (in_instr[6:0])
      OP_LOAD, OP_IMM, OP_JALR: dec_sel = SEL_ITYPE;
      OP_STORE:                 dec_sel = SEL_STYPE;
      OP_BRANCH:                dec_sel = SEL_BTYPE;
      OP_LUI, OP_AUIPC:         dec_sel = SEL_UTYPE;
      OP_JAL:                   dec_sel = SEL_JTYPE;
      OP_REG:                   dec_sel = SEL_NONE;
      default:                  dec_ill = 1'b1;
    endcase
  end

  SignExten u_sext (
    .ExtenSel (dec_sel),
    .imm_in   (in_instr[31:7]),
    .imm_out  (ext_imm)
  );

  always_comb begin
    new_ent.imm     = (dec_sel == SEL_NONE) ? 32'd0 : ext_imm;
    new_ent.pc      = in_pc;
    new_ent.sel     = dec_sel;
    new_ent.illegal = dec_ill;
  end

  fifo_ent_t [1:0] mem_q, mem_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [1:0]      count_q, count_d;
  // Held low through reset so in_ready only rises on the first edge after release.
  logic            rdy_q;
  logic            push, pop;

  assign in_ready  = rdy_q && (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = new_ent;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      rdy_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdy_q    <= 1'b1;
    end
  end

  assign out_imm     = mem_q[rd_ptr_q].imm;
  assign out_pc      = mem_q[rd_ptr_q].pc;
  assign out_sel     = mem_q[rd_ptr_q].sel;
  assign out_illegal = mem_q[rd_ptr_q].illegal;

endmodule
